// File: rtl/tx_fire_sequencer.sv
// tx_fire_sequencer: transmit-side firing sequencer for an 8-channel ultrasound front end.
// Walks every line and focal zone of a frame: pre-fire, focused bipolar pulses,
// damping dead time, receive window and a one-cycle end strobe. It also produces
// the receive-path gates. Every output comes straight from a flop.
module tx_fire_sequencer #(
  parameter int PR_LEN    = 16,
  parameter int HALF_PER  = 5,
  parameter int N_CYC     = 2,
  parameter int DAMP_LEN  = 64,
  parameter int RX_LEN    = 16000,
  parameter int NUM_LINES = 128,
  parameter int NUM_FOCUS = 4
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       Enable,
  output logic [7:0] Tx_P,
  output logic [7:0] Tx_N,
  output logic [7:0] Line_Num,
  output logic [1:0] Focus_Num,
  output logic       Pr_Gate,
  output logic       RX_Gate,
  output logic       Sample_Gate,
  output logic       End_Gate,
  output logic       Envelop,
  output logic       Busy
);

  localparam int PULSE_LEN = 2 * HALF_PER * N_CYC;
  localparam int PERIOD    = 2 * HALF_PER;
  localparam int FIRE_MAX  = NUM_FOCUS * 6 + PULSE_LEN;

  // The state counter must hold the longest state duration.
  localparam int MAX_A   = (PR_LEN > FIRE_MAX) ? PR_LEN : FIRE_MAX;
  localparam int MAX_B   = (DAMP_LEN > RX_LEN) ? DAMP_LEN : RX_LEN;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PR,
    S_FIRE,
    S_DAMP,
    S_RX,
    S_END
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       line_q, line_d;
  logic [1:0]       focus_q, focus_d;
  logic [7:0]       tx_p_q, tx_p_d;
  logic [7:0]       tx_n_q, tx_n_d;
  logic             pr_q, rx_q, sample_q, end_q, env_q, busy_q;
  logic [CNT_W-1:0] fire_last;

  // Symmetric aperture: the outer elements fire first and the centre fires last.
  function automatic int baseDelay(input int k);
    case (k)
      1, 6:    return 3;
      2, 5:    return 5;
      3, 4:    return 6;
      default: return 0;
    endcase
  endfunction

  // Returns the pulse level of one polarity. The input is the FIRE cycle index and
  // the channel delay.
  function automatic logic pulseOn(input int c, input int delay, input logic neg);
    int d;
    d = c - delay;
    pulseOn = 1'b0;
    if (d >= 0 && d < PULSE_LEN) begin
      if ((d % PERIOD) < HALF_PER) pulseOn = ~neg;
      else                         pulseOn = neg;
    end
  endfunction

  // Deeper focal zones stretch FIRE so that the most-delayed channel still completes its burst.
  assign fire_last = CNT_W'((int'(focus_q) + 1) * 6 + PULSE_LEN - 1);

  // Next-state logic: state sequencing, the per-state counter and the line/focus advance at END.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    line_d  = line_q;
    focus_d = focus_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (Enable) state_d = S_PR;
      end
      S_PR: begin
        if (cnt_q == CNT_W'(PR_LEN - 1)) begin
          state_d = S_FIRE;
          cnt_d   = '0;
        end
      end
      S_FIRE: begin
        if (cnt_q == fire_last) begin
          state_d = S_DAMP;
          cnt_d   = '0;
        end
      end
      S_DAMP: begin
        if (cnt_q == CNT_W'(DAMP_LEN - 1)) begin
          state_d = S_RX;
          cnt_d   = '0;
        end
      end
      S_RX: begin
        if (cnt_q == CNT_W'(RX_LEN - 1)) begin
          state_d = S_END;
          cnt_d   = '0;
        end
      end
      S_END: begin
        cnt_d = '0;
        if (Enable) begin
          state_d = S_PR;
          if (focus_q == 2'(NUM_FOCUS - 1)) begin
            focus_d = 2'd0;
            if (line_q == 8'(NUM_LINES - 1)) line_d = 8'd0;
            else                             line_d = line_q + 8'd1;
          end else begin
            focus_d = focus_q + 2'd1;
          end
        end else begin
          state_d = S_IDLE;
          line_d  = 8'd0;
          focus_d = 2'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulser drive for the coming cycle; the focus index cannot change while FIRE is running.
  always_comb begin
    tx_p_d = '0;
    tx_n_d = '0;
    if (state_d == S_FIRE) begin
      for (int k = 0; k < 8; k++) begin
        tx_p_d[k] = pulseOn(int'(cnt_d), (int'(focus_q) + 1) * baseDelay(k), 1'b0);
        tx_n_d[k] = pulseOn(int'(cnt_d), (int'(focus_q) + 1) * baseDelay(k), 1'b1);
      end
    end
  end

  // State, counter, indices and all outputs register together, so the gates line up with their state.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      line_q   <= 8'd0;
      focus_q  <= 2'd0;
      tx_p_q   <= 8'd0;
      tx_n_q   <= 8'd0;
      pr_q     <= 1'b0;
      rx_q     <= 1'b0;
      sample_q <= 1'b0;
      end_q    <= 1'b0;
      env_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      focus_q  <= focus_d;
      tx_p_q   <= tx_p_d;
      tx_n_q   <= tx_n_d;
      pr_q     <= (state_d == S_PR);
      rx_q     <= (state_d == S_DAMP) || (state_d == S_RX);
      sample_q <= (state_d == S_RX);
      end_q    <= (state_d == S_END);
      env_q    <= (state_d == S_END) && (line_q == 8'(NUM_LINES - 1)) &&
                  (focus_q == 2'(NUM_FOCUS - 1));
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign Tx_P        = tx_p_q;
  assign Tx_N        = tx_n_q;
  assign Line_Num    = line_q;
  assign Focus_Num   = focus_q;
  assign Pr_Gate     = pr_q;
  assign RX_Gate     = rx_q;
  assign Sample_Gate = sample_q;
  assign End_Gate    = end_q;
  assign Envelop     = env_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_tx_fire_sequencer.sv
// tb_tx_fire_sequencer: randomized Enable/reset stimulus for tx_fire_sequencer.
// The reference model treats a firing as a timeline of cycles. Every output is
// derived from the cycle's offset within the firing and from a flat line*focus index.
module tb_tx_fire_sequencer;

  localparam int PR_LEN    = 16;
  localparam int HALF_PER  = 5;
  localparam int N_CYC     = 2;
  localparam int DAMP_LEN  = 10;
  localparam int RX_LEN    = 40;
  localparam int NUM_LINES = 3;
  localparam int NUM_FOCUS = 4;

  logic       clk_50M;
  logic       reset;
  logic       Enable;
  logic [7:0] Tx_P, Tx_N, Line_Num;
  logic [1:0] Focus_Num;
  logic       Pr_Gate, RX_Gate, Sample_Gate, End_Gate, Envelop, Busy;

  int checks;
  int failures;

  // Reference model state: running flag, offset within the current firing, and indices.
  bit mActive;
  int mT;
  int mLine;
  int mFocus;

  int baseTab [8] = '{0, 3, 5, 6, 6, 5, 3, 0};

  tx_fire_sequencer #(
    .PR_LEN(PR_LEN), .HALF_PER(HALF_PER), .N_CYC(N_CYC), .DAMP_LEN(DAMP_LEN),
    .RX_LEN(RX_LEN), .NUM_LINES(NUM_LINES), .NUM_FOCUS(NUM_FOCUS)
  ) dut (
    .clk_50M(clk_50M), .reset(reset), .Enable(Enable),
    .Tx_P(Tx_P), .Tx_N(Tx_N), .Line_Num(Line_Num), .Focus_Num(Focus_Num),
    .Pr_Gate(Pr_Gate), .RX_Gate(RX_Gate), .Sample_Gate(Sample_Gate),
    .End_Gate(End_Gate), .Envelop(Envelop), .Busy(Busy)
  );

  // 50 MHz clock.
  initial begin
    clk_50M = 1'b0;
    forever #10 clk_50M = ~clk_50M;
  end

  function automatic int fireLen(input int f);
    return (f + 1) * 6 + 2 * HALF_PER * N_CYC;
  endfunction

  function automatic int firingLen(input int f);
    return PR_LEN + fireLen(f) + DAMP_LEN + RX_LEN + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rst);
    Enable = en;
    reset  = rst;
  endtask

  task automatic modelReset();
    mActive = 1'b0;
    mT      = 0;
    mLine   = 0;
    mFocus  = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic modelStep();
    int flat;
    if (reset) begin
      modelReset();
    end else if (!mActive) begin
      if (Enable) begin
        mActive = 1'b1;
        mT      = 0;
      end
    end else if (mT == firingLen(mFocus) - 1) begin
      if (Enable) begin
        flat   = (mLine * NUM_FOCUS + mFocus + 1) % (NUM_LINES * NUM_FOCUS);
        mLine  = flat / NUM_FOCUS;
        mFocus = flat % NUM_FOCUS;
        mT     = 0;
      end else begin
        modelReset();
      end
    end else begin
      mT++;
    end
  endtask

  // Compare every DUT output against what the model's timeline position implies.
  task automatic checkAll();
    logic [7:0] eP, eN;
    logic [5:0] eG;
    int fl, per, c, d, dly;
    eP = '0;
    eN = '0;
    eG = '0;
    if (mActive) begin
      fl  = fireLen(mFocus);
      per = firingLen(mFocus);
      c   = mT - PR_LEN;
      if (c >= 0 && c < fl) begin
        for (int k = 0; k < 8; k++) begin
          dly = (mFocus + 1) * baseTab[k];
          d   = c - dly;
          if (d >= 0 && d < 2 * HALF_PER * N_CYC) begin
            if (((d / HALF_PER) % 2) == 0) eP[k] = 1'b1;
            else                           eN[k] = 1'b1;
          end
        end
      end
      eG[5] = (mT < PR_LEN);
      eG[4] = (mT >= PR_LEN + fl) && (mT < per - 1);
      eG[3] = (mT >= PR_LEN + fl + DAMP_LEN) && (mT < per - 1);
      eG[2] = (mT == per - 1);
      eG[1] = eG[2] && (mLine == NUM_LINES - 1) && (mFocus == NUM_FOCUS - 1);
      eG[0] = 1'b1;
    end
    checkOutput("tx_p", Tx_P, eP);
    checkOutput("tx_n", Tx_N, eN);
    checkOutput("tx_overlap", Tx_P & Tx_N, 32'd0);
    checkOutput("gates_pr_rx_smp_end_env_busy",
                {Pr_Gate, RX_Gate, Sample_Gate, End_Gate, Envelop, Busy}, eG);
    checkOutput("line_focus", {Line_Num, Focus_Num}, {8'(mLine), 2'(mFocus)});
  endtask

  task automatic stepCycle();
    @(posedge clk_50M);
    modelStep();
    #1;
    checkAll();
  endtask

  // Run with Enable held high until the DUT opens its sampling window, within a fixed budget.
  task automatic waitForSample();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      stepCycle();
      if (Sample_Gate) seen = 1'b1;
    end
    checkOutput("wait_sample_gate", seen, 1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    modelReset();
    applyStimulus(1'b0, 1'b1);

    // Power-on reset, then a long idle stretch with Enable low.
    repeat (3) stepCycle();
    applyStimulus(1'b0, 1'b0);
    repeat (100) stepCycle();
    checkOutput("idle_busy", Busy, 0);

    // Continuous running across two full frames exercises focus and line wrap and Envelop.
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    checkOutput("first_pr", {Pr_Gate, Line_Num, Focus_Num}, {1'b1, 10'd0});
    repeat (2600) stepCycle();

    // Random Enable toggling; it matters only in IDLE and END.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) applyStimulus(~Enable, 1'b0);
      stepCycle();
    end

    // Reset asserted in the middle of RX clears everything without waiting for an edge.
    applyStimulus(1'b1, 1'b0);
    waitForSample();
    repeat ($urandom_range(1, 20)) stepCycle();
    applyStimulus(1'b1, 1'b1);
    #1;
    modelReset();
    checkAll();
    checkOutput("async_reset_zero",
                {Tx_P, Tx_N, Line_Num, Focus_Num, Pr_Gate, RX_Gate, Sample_Gate, End_Gate, Envelop, Busy},
                32'd0);
    repeat (2) stepCycle();
    applyStimulus(1'b1, 1'b0);
    repeat (300) stepCycle();

    // Dropping Enable mid-RX lets the firing finish; raising it restarts at index (0,0).
    waitForSample();
    applyStimulus(1'b0, 1'b0);
    repeat (200) stepCycle();
    checkOutput("idle_after_drop", {Busy, Line_Num, Focus_Num}, 32'd0);
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    checkOutput("restart_pr", {Pr_Gate, Line_Num, Focus_Num}, {1'b1, 10'd0});
    repeat (150) stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
